pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg_pkg.sv | 37 +++
 rtl/pipe_stage_reg_slot.sv | 70 +++++++
 rtl/pipe_stage_reg.sv | 168 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Shared definitions for the elastic pipeline register chain.
//  - PIPE_DEPTH_MAX     : largest supported chain depth
//  - CTRL_* positions   : bit offsets used by stages to pack/unpack the control
//                         field carried alongside the payload
//  - slot_op_e          : per-slot update operation (hold / load / kill)
//  - count_valid()      : population count of slot valid flags (+ skid entry)
// -----------------------------------------------------------------------------
package pipe_stage_reg_pkg;

  localparam int PIPE_DEPTH_MAX = 4;

  // Control-field layout shared by producer and consumer stages.
  localparam int CTRL_RF_W_EN_BIT      = 0;
  localparam int CTRL_MUX_RF_DATAW_LSB = 1;
  localparam int CTRL_MUX_RF_DATAW_W   = 2;
  localparam int CTRL_MUX_RF_REQW_LSB  = 3;
  localparam int CTRL_MUX_RF_REQW_W    = 2;

  typedef enum logic [1:0] {
    SLOT_HOLD = 2'd0,
    SLOT_LOAD = 2'd1,
    SLOT_KILL = 2'd2
  } slot_op_e;

  // Bits [PIPE_DEPTH_MAX-1:0] are chain slots, bit PIPE_DEPTH_MAX is the skid entry.
  function automatic logic [2:0] count_valid(input logic [PIPE_DEPTH_MAX:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i <= PIPE_DEPTH_MAX; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One register slot of the chain: a valid flag plus payload and control regs.
// Ports:
//  clk, rst_n      : clock, asynchronous active-low reset
//  load            : capture in_data/in_ctrl and mark the slot valid
//  kill            : mark the slot empty and zero its control (wins over load)
//  in_data/in_ctrl : incoming beat
//  valid/data/ctrl : held beat; ctrl is zero whenever valid is zero
// Data is left untouched on kill; only valid and ctrl are cleared, which is
// enough to keep writeback enables quiet for an empty slot.
// -----------------------------------------------------------------------------
module pipe_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              kill,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  slot_op_e          op;
  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [CTRL_W-1:0] ctrl_reg;

  always_comb begin
    op = SLOT_HOLD;
    if (kill) begin
      op = SLOT_KILL;
    end else if (load) begin
      op = SLOT_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      ctrl_reg  <= '0;
    end else begin
      case (op)
        SLOT_LOAD: begin
          valid_reg <= 1'b1;
          data_reg  <= in_data;
          ctrl_reg  <= in_ctrl;
        end
        SLOT_KILL: begin
          valid_reg <= 1'b0;
          ctrl_reg  <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;
  assign ctrl  = ctrl_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Elastic valid/ready register chain of DEPTH slots (1..4) carrying a payload
// and a control field between CPU stages, with synchronous flush.
// Optional feature macro: PIPE_SKID_EN (adds one skid entry and a registered
// in_ready, cutting the combinational out_ready -> in_ready path).
// Ports:
//  clk, rst_n                   : clock, asynchronous active-low reset
//  in_valid/in_ready            : upstream handshake
//  in_data/in_ctrl              : upstream beat
//  flush                        : kills every held beat at the next edge
//  out_valid/out_ready          : downstream handshake
//  out_data/out_ctrl            : last-slot beat (out_ctrl = 0 when empty)
//  occupancy                    : number of valid beats held (skid included)
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [$clog2(DEPTH+2)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH+2);

  // Beat offered to slot 0 (straight from the input, or from the skid entry).
  logic              head_valid;
  logic [DATA_W-1:0] head_data;
  logic [CTRL_W-1:0] head_ctrl;
  logic              chain_take;
  logic              skid_valid;
  logic [DEPTH-1:0]  valid_vec;

  // can_take: the slot will be free for a new beat after this edge, either
  // because it is empty (bubble collapse) or because its beat moves on.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_slot
    logic              valid;
    logic              can_take;
    logic              adv;
    logic              load;
    logic              kill;
    logic              src_valid;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] src_data;
    logic [CTRL_W-1:0] ctrl;
    logic [CTRL_W-1:0] src_ctrl;

    if (gi == DEPTH-1) begin : g_last
      assign adv = valid & out_ready;
    end else begin : g_mid
      assign adv = valid & gen_slot[gi+1].can_take;
    end

    if (gi == 0) begin : g_head
      assign src_valid = head_valid;
      assign src_data  = head_data;
      assign src_ctrl  = head_ctrl;
    end else begin : g_body
      assign src_valid = gen_slot[gi-1].valid;
      assign src_data  = gen_slot[gi-1].data;
      assign src_ctrl  = gen_slot[gi-1].ctrl;
    end

    assign can_take = !valid | adv;
    assign load     = can_take & src_valid;
    // Emptied when the beat leaves with nothing behind it, or on flush.
    assign kill     = flush | (adv & !load);

    pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .kill    (kill),
      .in_data (src_data),
      .in_ctrl (src_ctrl),
      .valid   (valid),
      .data    (data),
      .ctrl    (ctrl)
    );

    assign valid_vec[gi] = valid;
  end

  assign chain_take = gen_slot[0].can_take;
  assign out_valid  = gen_slot[DEPTH-1].valid;
  assign out_data   = gen_slot[DEPTH-1].data;
  assign out_ctrl   = gen_slot[DEPTH-1].ctrl;

`ifdef PIPE_SKID_EN
  logic              in_ready_reg;
  logic              accept;
  logic              skid_load;
  logic              skid_kill;
  logic              skid_valid_next;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign in_ready   = in_ready_reg & !flush;
  assign accept     = in_valid & in_ready;
  // The parked beat is older than anything arriving, so it feeds the chain first.
  assign head_valid = skid_valid | accept;
  assign head_data  = skid_valid ? skid_data : in_data;
  assign head_ctrl  = skid_valid ? skid_ctrl : in_ctrl;

  // Park an accepted beat when the chain cannot take it (or the skid is busy
  // feeding the chain this cycle).
  assign skid_load       = accept & (skid_valid | !chain_take);
  assign skid_kill       = flush | (skid_valid & chain_take & !skid_load);
  assign skid_valid_next = !flush & (skid_load | (skid_valid & !chain_take));

  // Ready is simply "skid free next cycle", so it depends only on flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_reg <= 1'b1;
    end else begin
      in_ready_reg <= !skid_valid_next;
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .kill    (skid_kill),
    .in_data (in_data),
    .in_ctrl (in_ctrl),
    .valid   (skid_valid),
    .data    (skid_data),
    .ctrl    (skid_ctrl)
  );
`else
  assign in_ready   = !flush & chain_take;
  assign head_valid = in_valid & in_ready;
  assign head_data  = in_data;
  assign head_ctrl  = in_ctrl;
  assign skid_valid = 1'b0;
`endif

  logic [PIPE_DEPTH_MAX:0] occ_vec;

  always_comb begin
    occ_vec                 = '0;
    occ_vec[DEPTH-1:0]      = valid_vec;
    occ_vec[PIPE_DEPTH_MAX] = skid_valid;
  end

  assign occupancy = OCC_W'(count_valid(occ_vec));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Scoreboard bench for pipe_stage_reg (DEPTH=3). Accepted beats are queued by
// the request-side process; a separate monitor pops and compares each beat the
// DUT delivers. The model is a plain FIFO whose size is the expected occupancy.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int DEPTH  = 3;
  localparam int OCC_W  = $clog2(DEPTH+2);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [OCC_W-1:0]  occupancy;

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [DATA_W+CTRL_W-1:0] beat_t;
  beat_t sb[$];
  int    n_vec   = 0;
  int    n_err   = 0;
  int    cyc     = 0;
  int    exp_occ = 0;
  int    t0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Ready rule from the model: room for one more beat, or the head leaves now.
  function automatic bit model_ready();
`ifdef PIPE_SKID_EN
    return !flush && (exp_occ <= DEPTH);
`else
    return !flush && ((exp_occ < DEPTH) || out_ready);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge bookkeeping: flush and reset discard everything held.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n || flush) sb.delete();
    exp_occ = sb.size();
  end

  // Request side: check ready/occupancy/bubble ctrl, record accepted beats.
  always @(negedge clk) begin
    if (rst_n) begin
      bit er;
      er = model_ready();
      check("in_ready", in_ready, er);
      check("occupancy", occupancy, exp_occ);
      if (!out_valid) check("bubble_ctrl", out_ctrl, 0);
      if (in_valid && er) sb.push_back({in_data, in_ctrl});
    end
  end

  // Monitor: every delivered beat must be the oldest outstanding one.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got data %h ctrl %h, required none outstanding", out_data, out_ctrl);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("beat", {out_data, out_ctrl}, e);
        $display("beat out: data=%h ctrl=%h (expected data=%h ctrl=%h)", out_data, out_ctrl,
                 e[DATA_W+CTRL_W-1:CTRL_W], e[CTRL_W-1:0]);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready", in_ready, 1);
    tick();

    // Latency and back-to-back throughput: 0x11, 0x22, 0x33
    t0 = cyc;
    fork
      begin
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h11; in_ctrl = 8'h01; tick();
        in_data   = 32'h22; in_ctrl = 8'h02; tick();
        in_data   = 32'h33; in_ctrl = 8'h03; tick();
        in_valid  = 1'b0;
      end
      begin
        bit seen;
        int tv;
        seen = 1'b0;
        tv   = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1'b1;
            tv   = cyc;
          end
        end
        check("first_out_latency", seen ? 64'(tv - t0) : 64'hFFFF, DEPTH);
        repeat (2) begin
          @(negedge clk);
          check("back_to_back", out_valid, 1);
        end
      end
    join
    repeat (3) tick();

    // Stall: output held stable, upstream fills, ready drops
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hB0 + 32'(i);
      in_ctrl  = 8'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stall_out_valid", out_valid, 1);
    check("stall_hold_data", out_data, 32'hB0);
    tick();
    @(negedge clk);
    check("stall_hold_data2", out_data, 32'hB0);
    tick();
    out_ready = 1'b1;
    repeat (10) tick();

    // Flush with two beats held and a beat offered in the flush cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA0; in_ctrl = 8'h81; tick();
    in_data   = 32'hA1; in_ctrl = 8'h81; tick();
    in_valid  = 1'b0;
    repeat (2) tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hEE;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_ctrl", out_ctrl, 0);
    check("flush_occupancy", occupancy, 0);
    tick();

    // Bubble collapse: every other cycle, downstream stalled
    out_ready = 1'b0;
    for (int i = 0; i < 2*DEPTH; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 32'hC0 + 32'(i);
      in_ctrl  = 8'h40 | 8'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("collapse_occupancy", occupancy, DEPTH);
    check("collapse_out_data", out_data, 32'hC0);
    tick();
    out_ready = 1'b1;
    repeat (8) tick();

`ifdef PIPE_SKID_EN
    // Skid: downstream drops under continuous input; one beat parks
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      out_ready = (i < 6);
      in_data   = 32'hD0 + 32'(i);
      in_ctrl   = 8'h20 | 8'(i);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("skid_occupancy", occupancy, DEPTH + 1);
    check("skid_in_ready", in_ready, 0);
    tick();
    out_ready = 1'b1;
    repeat (8) tick();
`endif

    // Random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_data   = $urandom;
      in_ctrl   = 8'($urandom);
      if (i == 300) begin
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_out_ctrl", out_ctrl, 0);
        check("async_rst_occupancy", occupancy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    // Drain: everything accepted must come out
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    tick();
    @(negedge clk);
    check("drain_outstanding", sb.size(), 0);
    check("drain_occupancy", occupancy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
